pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max memory-wait cycles before error.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 hazard_detected  input  1  RAW hazard from the hazard unit; same signal as the ID stage input.
REQ-007 branch_taken  input  1  branch resolved taken in EXE this cycle.
REQ-008 mem_req  input  1  MEM stage holds a load or store this cycle.
REQ-009 mem_ready  input  1  memory completes the MEM-stage access this cycle.
REQ-010 freeze_if  output  1  hold PC and the IF stage register.
REQ-011 freeze_id  output  1  hold the ID stage register; drives its freeze input.
REQ-012 freeze_back  output  1  hold the EXE and MEM stage registers.
REQ-013 flush_if  output  1  clear the IF stage register.
REQ-014 flush_id  output  1  clear the ID stage register; drives its flush input.
REQ-015 mem_error  output  1  sticky: memory-wait timeout occurred.
REQ-016 hazard_stalls, mem_stalls, flushes  output  CNT_WIDTH each  performance counters.
REQ-017 state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 RECOVER.

Function
REQ-018 mem_stall SHALL equal mem_req & ~mem_ready & ~mem_error; all control outputs are combinational from inputs and state.
REQ-019 When mem_stall=1: freeze_if=freeze_id=freeze_back=1 and flush_if=flush_id=0.
REQ-020 When mem_stall=0 and branch_taken=1: flush_if=flush_id=1 and all freezes are 0; the branch overrides a coincident hazard.
REQ-021 When mem_stall=0, branch_taken=0 and hazard_detected=1: freeze_if=1, freeze_id=0, flush_id=0, freeze_back=0; the ID stage inserts the bubble.
REQ-022 In all other cases, all five control outputs SHALL be 0.
REQ-023 Priority SHALL be mem_stall > branch_taken > hazard_detected; freeze and flush never assert together on one register.
REQ-024 FSM in RUN: mem_stall=1 moves to MEM_WAIT and loads wait_cnt=1; otherwise stays in RUN.
REQ-025 FSM in MEM_WAIT: mem_ready=1 moves to RUN; wait_cnt==TIMEOUT_CYCLES moves to RECOVER and sets mem_error; otherwise wait_cnt increments.
REQ-026 In RECOVER, mem_error=1 forces mem_stall=0 so the pipeline proceeds; the FSM moves to RUN on the next cycle.
REQ-027 mem_error SHALL stay 1 until rst.
REQ-028 mem_ready=1 on the same cycle as mem_req=1 SHALL produce zero stall cycles and no state change.
REQ-029 mem_ready without mem_req SHALL be ignored.
REQ-030 A branch_taken held during a mem stall SHALL take effect on the first cycle mem_stall falls to 0.
REQ-031 hazard_stalls SHALL increment on each cycle with mem_stall=0, branch_taken=0 and hazard_detected=1.
REQ-032 mem_stalls SHALL increment on each cycle with mem_stall=1.
REQ-033 flushes SHALL increment on each cycle with flush_id=1.
REQ-034 All counters SHALL saturate at all-ones and never wrap.

Reset
REQ-035 rst=1 SHALL force: state=RUN, wait_cnt=0, mem_error=0, all counters 0.
REQ-036 While rst=1, all freeze and flush outputs SHALL be 0 regardless of inputs.
REQ-037 rst asserted mid-MEM_WAIT SHALL abandon the wait; the FSM is in RUN on the first cycle after rst deasserts.

Configuration
REQ-038 Macro SEQ_PERF_COUNTERS_EN SHALL select whether the performance counters are built.
REQ-039 With SEQ_PERF_COUNTERS_EN defined: the three counters are implemented as specified in REQ-031 to REQ-034.
REQ-040 Without SEQ_PERF_COUNTERS_EN: the counters are not instantiated and their outputs are tied to 0; all other behaviour is unchanged.

Verification
REQ-041 Hazard: hazard_detected=1 for 2 cycles, no mem_req -> freeze_if=1 for 2 cycles, freeze_id=0, hazard_stalls=2.
REQ-042 Mem wait: mem_req=1 with mem_ready low for 3 cycles then high -> all freezes=1 for 3 cycles, state 0,1,1,1,0, mem_stalls=3.
REQ-043 Branch during stall: branch_taken=1 held across a 2-cycle mem stall -> flush_if=flush_id=0 while stalled, then =1 exactly on release cycle, flushes=1.
REQ-044 Timeout: TIMEOUT_CYCLES=4, mem_ready never asserted -> state enters RECOVER after 4 wait cycles, mem_error=1 and sticky, freezes drop to 0.
REQ-045 Reset mid-wait: rst pulsed in MEM_WAIT -> next cycle state=RUN, counters=0, mem_error=0.
REQ-046 Saturation: CNT_WIDTH=4, 20 hazard cycles -> hazard_stalls=15; build without SEQ_PERF_COUNTERS_EN -> all counters read 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush controller for a five-stage pipeline.
// Arbitrates memory stalls, taken branches and RAW hazards into freeze/flush
// controls, and watches MEM-stage waits for a timeout.
// Optional feature macro: SEQ_PERF_COUNTERS_EN builds the saturating
// performance counters. Without it, the counter outputs are tied to 0.

module pipeline_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 freeze_if,
  output logic                 freeze_id,
  output logic                 freeze_back,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] hazard_stalls,
  output logic [CNT_WIDTH-1:0] mem_stalls,
  output logic [CNT_WIDTH-1:0] flushes,
  output logic [1:0]           state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RECOVER  = 2'd2
  } state_t;

  state_t            cur_state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              mem_error_next;
  logic              mem_stall;

  // Once the timeout has fired the memory is treated as dead, so stalls stop.
  assign mem_stall = mem_req & ~mem_ready & ~mem_error;
  assign state     = cur_state;

  // Control arbitration: memory stall beats branch, branch beats hazard.
  always_comb begin
    freeze_if   = 1'b0;
    freeze_id   = 1'b0;
    freeze_back = 1'b0;
    flush_if    = 1'b0;
    flush_id    = 1'b0;
    if (rst) begin
      freeze_if = 1'b0;
    end else if (mem_stall) begin
      freeze_if   = 1'b1;
      freeze_id   = 1'b1;
      freeze_back = 1'b1;
    end else if (branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (hazard_detected) begin
      // IF/PC hold; ID keeps flowing and inserts the bubble itself.
      freeze_if = 1'b1;
    end else begin
      freeze_if = 1'b0;
    end
  end

  // Next-state logic for the memory-wait watchdog.
  always_comb begin
    next_state     = cur_state;
    wait_cnt_next  = wait_cnt;
    mem_error_next = mem_error;
    case (cur_state)
      ST_RUN: begin
        if (mem_stall) begin
          next_state    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          next_state    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          next_state     = ST_RECOVER;
          mem_error_next = 1'b1;
          wait_cnt_next  = '0;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      ST_RECOVER: begin
        next_state = ST_RUN;
      end
      default: begin
        next_state    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= wait_cnt_next;
      mem_error <= mem_error_next;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic hazard_cycle;

  assign hazard_cycle = ~mem_stall & ~branch_taken & hazard_detected;

  // Hazard-stall counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_stalls <= '0;
    end else if (hazard_cycle && (hazard_stalls != '1)) begin
      hazard_stalls <= hazard_stalls + CNT_WIDTH'(1);
    end else begin
      hazard_stalls <= hazard_stalls;
    end
  end

  // Memory-stall counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_stalls <= '0;
    end else if (mem_stall && (mem_stalls != '1)) begin
      mem_stalls <= mem_stalls + CNT_WIDTH'(1);
    end else begin
      mem_stalls <= mem_stalls;
    end
  end

  // Flush counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      flushes <= '0;
    end else if (flush_id && (flushes != '1)) begin
      flushes <= flushes + CNT_WIDTH'(1);
    end else begin
      flushes <= flushes;
    end
  end
`else
  assign hazard_stalls = '0;
  assign mem_stalls    = '0;
  assign flushes       = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (TIMEOUT_CYCLES=4, CNT_WIDTH=4).
// Per-cycle expectations are queued when inputs are driven and checked on the
// following falling edge; counters are checked against hand-derived totals.

module tb_pipeline_sequencer;

  localparam int CW = 4;

  // Control vector order: {freeze_if, freeze_id, freeze_back, flush_if, flush_id}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_MEM  = 5'b11100;
  localparam logic [4:0] C_BR   = 5'b00011;
  localparam logic [4:0] C_HZ   = 5'b10000;

  typedef struct packed {
    logic [4:0] ctl;
    logic [1:0] st;
    logic       er;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          hazard_detected;
  logic          branch_taken;
  logic          mem_req;
  logic          mem_ready;
  logic          freeze_if;
  logic          freeze_id;
  logic          freeze_back;
  logic          flush_if;
  logic          flush_id;
  logic          mem_error;
  logic [CW-1:0] hazard_stalls;
  logic [CW-1:0] mem_stalls;
  logic [CW-1:0] flushes;
  logic [1:0]    state;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  pipeline_sequencer #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .freeze_if       (freeze_if),
    .freeze_id       (freeze_id),
    .freeze_back     (freeze_back),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .mem_error       (mem_error),
    .hazard_stalls   (hazard_stalls),
    .mem_stalls      (mem_stalls),
    .flushes         (flushes),
    .state           (state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue its expectation, check it at negedge.
  task automatic cyc(input string nm, input logic rs, input logic hz,
                     input logic br, input logic rq, input logic rd,
                     input logic [4:0] ctl, input logic [1:0] st,
                     input logic er);
    exp_t e;
    logic [4:0] got;
    rst = rs; hazard_detected = hz; branch_taken = br;
    mem_req = rq; mem_ready = rd;
    sb.push_back('{ctl: ctl, st: st, er: er});
    @(negedge clk);
    e   = sb.pop_front();
    got = {freeze_if, freeze_id, freeze_back, flush_if, flush_id};
    n_tests++;
    if (got !== e.ctl) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", nm, got, e.ctl);
    end
    n_tests++;
    if (state !== e.st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", nm, state, e.st);
    end
    n_tests++;
    if (mem_error !== e.er) begin
      n_fail++;
      $display("FAIL %s mem_error: got %b expected %b", nm, mem_error, e.er);
    end
    @(posedge clk);
    #1;
  endtask

  // Check the three counters (all zero when the counters are not built).
  task automatic check_cnt(input string nm, input logic [CW-1:0] h,
                           input logic [CW-1:0] m, input logic [CW-1:0] f);
    logic [CW-1:0] eh, em, ef;
`ifdef SEQ_PERF_COUNTERS_EN
    eh = h; em = m; ef = f;
`else
    eh = '0; em = '0; ef = '0;
    if (h !== eh || m !== em || f !== ef) begin
      eh = '0;
    end
`endif
    n_tests++;
    if (hazard_stalls !== eh) begin
      n_fail++;
      $display("FAIL %s hazard_stalls: got %0d expected %0d", nm, hazard_stalls, eh);
    end
    n_tests++;
    if (mem_stalls !== em) begin
      n_fail++;
      $display("FAIL %s mem_stalls: got %0d expected %0d", nm, mem_stalls, em);
    end
    n_tests++;
    if (flushes !== ef) begin
      n_fail++;
      $display("FAIL %s flushes: got %0d expected %0d", nm, flushes, ef);
    end
  endtask

  task automatic test_reset();
    // Everything asserted while in reset: outputs must stay quiet.
    cyc("rst_all_in", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_NONE, 2'd0, 1'b0);
    cyc("rst_hold",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("rst_cnt", 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_hazard();
    cyc("hz1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_HZ,   2'd0, 1'b0);
    cyc("hz2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_HZ,   2'd0, 1'b0);
    cyc("hz_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("hz_cnt", 4'd2, 4'd0, 4'd0);
  endtask

  task automatic test_mem_wait();
    cyc("mw_rst",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    cyc("mw1",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM,  2'd0, 1'b0);
    cyc("mw2_hz",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_MEM,  2'd1, 1'b0);
    cyc("mw3",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM,  2'd1, 1'b0);
    cyc("mw_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 2'd1, 1'b0);
    cyc("mw_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("mw_cnt", 4'd0, 4'd3, 4'd0);
  endtask

  task automatic test_zero_wait();
    cyc("zw_hit",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 2'd0, 1'b0);
    cyc("zw_rdy",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 2'd0, 1'b0);
    cyc("zw_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("zw_cnt", 4'd0, 4'd3, 4'd0);
  endtask

  task automatic test_branch_in_stall();
    cyc("bs_rst",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    cyc("bs1",     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_MEM,  2'd0, 1'b0);
    cyc("bs2",     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_MEM,  2'd1, 1'b0);
    cyc("bs_rel",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,   2'd1, 1'b0);
    cyc("bs_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("bs_cnt", 4'd0, 4'd2, 4'd1);
    // Branch overrides a coincident hazard; the hazard is not counted.
    cyc("br_hz",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   2'd0, 1'b0);
    check_cnt("br_hz_cnt", 4'd0, 4'd2, 4'd2);
  endtask

  task automatic test_timeout();
    cyc("to_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    cyc("to_run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM,  2'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc($sformatf("to_wait%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1, 1'b0);
    end
    cyc("to_recover", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NONE, 2'd2, 1'b1);
    cyc("to_back",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_NONE, 2'd0, 1'b1);
    cyc("to_sticky",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_HZ,   2'd0, 1'b1);
    cyc("to_sticky2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NONE, 2'd0, 1'b1);
    check_cnt("to_cnt", 4'd1, 4'd5, 4'd0);
    cyc("to_clr",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b1);
    cyc("to_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    cyc("rm1",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM,  2'd0, 1'b0);
    cyc("rm2",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_MEM,  2'd1, 1'b0);
    check_cnt("rm_pre", 4'd0, 4'd2, 4'd0);
    cyc("rm_rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_NONE, 2'd1, 1'b0);
    cyc("rm_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    check_cnt("rm_cnt", 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_saturation();
    cyc("sat_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("sat_hz%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_HZ, 2'd0, 1'b0);
    end
    check_cnt("sat_cnt", 4'd15, 4'd0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_hazard();
    test_mem_wait();
    test_zero_wait();
    test_branch_in_stall();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
